prescaled_counter: RTL and testbench

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

---
 rtl/prescaled_counter.sv | 153 +++++++++++++++
 tb/tb_prescaled_counter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/prescaled_counter.sv
// Up/down counter advanced by a clk prescaler tick or a synchronized push-button step.
// Define COUNTER_DEBOUNCE_EN to debounce the step input over DB_CYCLES clocks.
module prescaled_counter #(
  parameter int WIDTH     = 4,
  parameter int DIV       = 12000000,
  parameter bit SATURATE  = 1'b0,
  parameter int DB_CYCLES = 120000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step_n,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [PW-1:0]    pre_r, pre_nxt_s;
  logic [WIDTH-1:0] count_r, count_nxt_s;
  logic             tick_r, tick_nxt_s;
  logic             tc_r, tc_nxt_s;
  logic             sync1_r, sync2_r;
  logic             db_state_r, db_state_nxt_s;
  logic [1:0]       rdy_r;
  logic             arm_r;
  logic             step_r;
  logic             step_fall_s;
  logic             pre_term_s;
  logic             advance_s;
  logic             at_bound_s;

`ifdef COUNTER_DEBOUNCE_EN
  localparam int             DBW     = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic [DBW-1:0] db_cnt_r, db_cnt_nxt_s;

  // Debounce: the synchronized level must differ from the held state for DB_CYCLES samples
  always_comb begin
    db_cnt_nxt_s   = db_cnt_r;
    db_state_nxt_s = db_state_r;
    step_fall_s    = 1'b0;
    if (sync2_r != db_state_r) begin
      if (db_cnt_r == DB_LAST) begin
        db_cnt_nxt_s   = DBW'(0);
        db_state_nxt_s = sync2_r;
        step_fall_s    = ~sync2_r;
      end else begin
        db_cnt_nxt_s = db_cnt_r + DBW'(1);
      end
    end else begin
      db_cnt_nxt_s = DBW'(0);
    end
  end

  // Debounce counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_r <= DBW'(0);
    end else begin
      db_cnt_r <= db_cnt_nxt_s;
    end
  end
`else
  // Without debounce the held state is just the previous synchronized sample
  always_comb begin
    db_state_nxt_s = sync2_r;
    step_fall_s    = db_state_r & ~sync2_r;
  end
`endif

  // Synchronizer, step pulse, and arming so a button held through reset is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      db_state_r <= 1'b1;
      rdy_r      <= 2'b00;
      arm_r      <= 1'b0;
      step_r     <= 1'b0;
    end else begin
      sync1_r    <= step_n;
      sync2_r    <= sync1_r;
      db_state_r <= db_state_nxt_s;
      rdy_r      <= {rdy_r[0], 1'b1};
      arm_r      <= arm_r | (rdy_r[1] & sync2_r);
      step_r     <= step_fall_s & arm_r;
    end
  end

  assign pre_term_s = en && (pre_r == PRE_LAST);
  assign advance_s  = pre_term_s | step_r;
  assign at_bound_s = dir ? (count_r == CNT_MAX) : (count_r == WIDTH'(0));

  // Prescaler and counter next state; load overrides everything, including a pending step
  always_comb begin
    pre_nxt_s   = pre_r;
    count_nxt_s = count_r;
    tick_nxt_s  = 1'b0;
    tc_nxt_s    = 1'b0;
    if (load) begin
      pre_nxt_s   = PW'(0);
      count_nxt_s = load_val;
    end else begin
      if (en) begin
        pre_nxt_s = pre_term_s ? PW'(0) : (pre_r + PW'(1));
      end else begin
        pre_nxt_s = pre_r;
      end
      tick_nxt_s = pre_term_s;
      if (advance_s) begin
        tc_nxt_s = at_bound_s;
        if (at_bound_s && SATURATE) begin
          count_nxt_s = count_r;
        end else if (dir) begin
          count_nxt_s = count_r + CNT_ONE;
        end else begin
          count_nxt_s = count_r - CNT_ONE;
        end
      end else begin
        tc_nxt_s = 1'b0;
      end
    end
  end

  // Counter state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r   <= PW'(0);
      count_r <= WIDTH'(0);
      tick_r  <= 1'b0;
      tc_r    <= 1'b0;
    end else begin
      pre_r   <= pre_nxt_s;
      count_r <= count_nxt_s;
      tick_r  <= tick_nxt_s;
      tc_r    <= tc_nxt_s;
    end
  end

  assign count = count_r;
  assign tick  = tick_r;
  assign tc    = tc_r;

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed bench for prescaled_counter: wrap and saturate instances share one stimulus.
module tb_prescaled_counter;

  logic       clk = 1'b0;
  logic       rst, en, dir, load, step_n;
  logic [3:0] load_val;
  logic [3:0] cnt_w, cnt_s;
  logic       tick_w, tick_s, tc_w, tc_s;

  int tests = 0;
  int fails = 0;

`ifdef COUNTER_DEBOUNCE_EN
  localparam int LAT      = 10;
  localparam int BOUNCE_C = 7;
  localparam int BURST_C  = 8;
`else
  localparam int LAT      = 3;
  localparam int BOUNCE_C = 9;
  localparam int BURST_C  = 10;
`endif

  prescaled_counter #(.WIDTH(4), .DIV(4), .SATURATE(1'b0), .DB_CYCLES(8)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .step_n(step_n), .count(cnt_w), .tick(tick_w), .tc(tc_w)
  );

  prescaled_counter #(.WIDTH(4), .DIV(4), .SATURATE(1'b1), .DB_CYCLES(8)) u_sat (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .step_n(step_n), .count(cnt_s), .tick(tick_s), .tc(tc_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; load_val = 4'd0; step_n = 1'b1;
    cyc(3);
    check("rst_cnt_w", 32'(cnt_w), 32'd0);
    check("rst_cnt_s", 32'(cnt_s), 32'd0);
    check("rst_tick", 32'(tick_w), 32'd0);
    check("rst_tc", 32'(tc_w), 32'd0);

    // free-running up count: ticks on edges 4, 8, 12
    rst = 1'b0; en = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      cyc(1);
      check("run_tick", 32'(tick_w), 32'((e % 4) == 0));
      check("run_cnt", 32'(cnt_w), 32'(e / 4));
      check("run_tc", 32'(tc_w), 32'd0);
    end

    // async reset at pre=2, count=5
    load = 1'b1; load_val = 4'd5; cyc(1); load = 1'b0;
    check("load5_cnt", 32'(cnt_w), 32'd5);
    check("load5_tick", 32'(tick_w), 32'd0);
    cyc(2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cnt_w", 32'(cnt_w), 32'd0);
    check("async_rst_cnt_s", 32'(cnt_s), 32'd0);
    cyc(1);
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      cyc(1);
      check("post_rst_tick", 32'(tick_w), 32'(e == 4));
      check("post_rst_cnt", 32'(cnt_w), 32'(e == 4));
      check("post_rst_tc", 32'(tc_w), 32'd0);
    end

    // up at 15: wrap vs saturate
    load = 1'b1; load_val = 4'd15; dir = 1'b1; cyc(1); load = 1'b0;
    cyc(3);
    check("up15_pre_tick", 32'(tick_w), 32'd0);
    cyc(1);
    check("up15_tick", 32'(tick_s), 32'd1);
    check("up15_cnt_w", 32'(cnt_w), 32'd0);
    check("up15_tc_w", 32'(tc_w), 32'd1);
    check("up15_cnt_s", 32'(cnt_s), 32'd15);
    check("up15_tc_s", 32'(tc_s), 32'd1);
    cyc(1);
    check("up15_tc_w_end", 32'(tc_w), 32'd0);
    check("up15_tc_s_end", 32'(tc_s), 32'd0);

    // down at 0: wrap vs saturate, then one ordinary down step
    load = 1'b1; load_val = 4'd0; dir = 1'b0; cyc(1); load = 1'b0;
    cyc(4);
    check("dn0_cnt_w", 32'(cnt_w), 32'd15);
    check("dn0_tc_w", 32'(tc_w), 32'd1);
    check("dn0_cnt_s", 32'(cnt_s), 32'd0);
    check("dn0_tc_s", 32'(tc_s), 32'd1);
    cyc(4);
    check("dn15_cnt_w", 32'(cnt_w), 32'd14);
    check("dn15_tc_w", 32'(tc_w), 32'd0);
    check("dn0b_cnt_s", 32'(cnt_s), 32'd0);
    check("dn0b_tc_s", 32'(tc_s), 32'd1);

    // bouncing button with prescaler stopped
    en = 1'b0; dir = 1'b1; load = 1'b1; load_val = 4'd7; cyc(1); load = 1'b0;
    step_n = 1'b0; cyc(3); step_n = 1'b1; cyc(3);
    step_n = 1'b0; cyc(3); step_n = 1'b1; cyc(3);
    check("bounce_cnt", 32'(cnt_w), 32'(BOUNCE_C));
    step_n = 1'b0; cyc(20); step_n = 1'b1; cyc(20);
    check("press_cnt_w", 32'(cnt_w), 32'(BURST_C));
    check("press_cnt_s", 32'(cnt_s), 32'(BURST_C));
    check("press_tick", 32'(tick_w), 32'd0);

    // step landing on the same edge as the prescaler tick
    en = 1'b1; load = 1'b1; load_val = 4'd2; cyc(1); load = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      cyc(1);
      if (e == 11 - LAT) step_n = 1'b0;
      if (e == 11) check("coin_before", 32'(cnt_w), 32'd4);
      if (e == 12) begin
        check("coin_cnt", 32'(cnt_w), 32'd5);
        check("coin_tick", 32'(tick_w), 32'd1);
        check("coin_tc", 32'(tc_w), 32'd0);
      end
    end
    step_n = 1'b1; en = 1'b0; cyc(15);
    check("coin_after", 32'(cnt_w), 32'd5);

    // button held through reset is ignored until released and pressed again
    step_n = 1'b0; rst = 1'b1; cyc(2); rst = 1'b0;
    cyc(20);
    check("held_cnt_w", 32'(cnt_w), 32'd0);
    check("held_cnt_s", 32'(cnt_s), 32'd0);
    step_n = 1'b1; cyc(15);
    step_n = 1'b0; cyc(15);
    check("repress_cnt", 32'(cnt_w), 32'd1);
    step_n = 1'b1; cyc(12);
    check("release_cnt", 32'(cnt_w), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
